// File: rtl/trade_risk_initiator.sv
// rtl/trade_risk_initiator.sv - per-client risk check requester for the upstream risk memory
// Reads the client word, checks the trade against its limit, writes back on accept, then responds.
module trade_risk_initiator #(
  parameter int IDX_W  = 9,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic [IDX_W-1:0] ord_client,
  input  logic             ord_setmax,
  input  logic [15:0]      ord_value,
  output logic [IDX_W-1:0] mem_rdindex,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_accept,
  output logic [IDX_W-1:0] resp_client,
  output logic [15:0]      resp_accum,
  output logic [15:0]      reject_cnt
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_CHECK,
    S_WRITE,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] r_client;
  logic             r_setmax;
  logic [15:0]      r_value;
  logic [31:0]      r_word;
  logic             r_accept;
  logic [15:0]      r_accum;
  logic [15:0]      r_rej_cnt;

  logic [16:0]      w_sum;
  logic             w_reject;
  logic             w_fire;
  logic             w_resp_done;
  logic             w_last_rd;

  assign ord_ready   = (r_state == S_IDLE) && !rst;
  assign w_fire      = ord_valid && ord_ready;
  assign w_resp_done = (r_state == S_RESP) && resp_ready;
  assign w_last_rd   = (r_state == S_RD_WAIT) && (r_cnt == 1);

  // Carry bit catches accumulator wrap before the limit compare.
  assign w_sum    = {1'b0, r_word[15:0]} + {1'b0, r_value};
  assign w_reject = (r_word[31:16] == 16'h0000) || w_sum[16] || (w_sum[15:0] > r_word[31:16]);

  assign mem_rdindex = (r_state == S_IDLE) ? '0 : r_client;
  assign mem_we      = (r_state == S_WRITE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_accept = r_accept;
  assign resp_client = r_client;
  assign resp_accum  = r_accum;
  assign reject_cnt  = r_rej_cnt;

  always_comb begin
    mem_wdata = 32'h0000_0000;
    if (r_state == S_WRITE) begin
      mem_wdata = r_setmax ? {r_value, 16'h0000} : {16'h0000, r_value};
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          if (ord_setmax) begin
            // The memory reads an upper half of 0/1 as an accumulate, so such maxima are refused.
            w_next = (ord_value <= 16'd1) ? S_RESP : S_WRITE;
          end else begin
            w_next     = S_RD_WAIT;
            w_cnt_next = RD_CNT;
          end
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == 1) begin
          w_next = S_CHECK;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_CHECK: begin
        w_next = w_reject ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        w_next     = S_WR_WAIT;
        w_cnt_next = WR_CNT;
      end
      S_WR_WAIT: begin
        if (r_cnt == 1) begin
          w_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_client  <= '0;
      r_setmax  <= 1'b0;
      r_value   <= 16'h0000;
      r_word    <= 32'h0000_0000;
      r_accept  <= 1'b0;
      r_accum   <= 16'h0000;
      r_rej_cnt <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_fire) begin
        r_client <= ord_client;
        r_setmax <= ord_setmax;
        r_value  <= ord_value;
        if (ord_setmax) begin
          r_accept <= (ord_value > 16'd1);
          r_accum  <= 16'h0000;
        end
      end
      if (w_last_rd) begin
        r_word <= mem_rdata;
      end
      if (r_state == S_CHECK) begin
        r_accept <= !w_reject;
        r_accum  <= w_reject ? r_word[15:0] : w_sum[15:0];
      end
      if (w_resp_done && !r_accept && (r_rej_cnt != 16'hFFFF)) begin
        r_rej_cnt <= r_rej_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/trade_risk_initiator.md
# trade_risk_initiator

Client-side requester for the upstream per-client risk memory. Accepts trade orders and max-limit updates. For trades it reads the client's 32-bit word (`[31:16]` max allowed, `[15:0]` accumulated), checks the limit, and writes the accumulation back only on accept. It then returns an accept/reject response. It sits between the order-entry pipeline and the upstream memory model, and absorbs that model's fixed read and write latencies.

## Interface
- `IDX_W`, 9: client index width (512-entry memory).
- `RD_LAT`, 4: cycles from index presented to read data valid (≥1).
- `WR_LAT`, 6: cycles the memory is busy after a write pulse (≥1).
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `ord_valid` in 1: order request valid.
- `ord_ready` out 1: block idle and able to accept.
- `ord_client` in IDX_W: client index.
- `ord_setmax` in 1: 1 = set-max command, 0 = trade.
- `ord_value` in 16: trade amount, or new max when `ord_setmax`=1.
- `mem_rdindex` out IDX_W: memory index.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out 32: memory write word.
- `mem_rdata` in 32: memory read word.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response consumed.
- `resp_accept` out 1: 1 = order applied.
- `resp_client` out IDX_W: client index of the response.
- `resp_accum` out 16: resulting accumulated amount.
- `reject_cnt` out 16: saturating count of rejected orders.

## Operation
- Order handshake fires when `ord_valid` and `ord_ready` are both high on a rising edge. Client, setmax and value are latched at that edge.
- `ord_ready` = (state==IDLE) && !rst.
- States: IDLE, RD_WAIT, CHECK, WRITE, WR_WAIT, RESP.
- Trade path:
  - IDLE → RD_WAIT, with the counter loaded to RD_LAT.
  - `mem_rdata` is captured on the last RD_WAIT cycle.
  - CHECK computes sum = accum + amount at 17 bits.
  - Reject if max==0, sum[16]==1, or sum[15:0] > max. Reject goes to RESP with `resp_accum` = old accum and no write.
  - Otherwise go to WRITE with `mem_wdata` = {16'h0000, amount}, so the memory adds amount to `[15:0]`. Then WR_WAIT for WR_LAT cycles, then RESP with `resp_accum` = sum[15:0].
- Set-max path:
  - If value ≤ 1: IDLE → RESP directly with reject and no memory access. The memory treats an upper half ≤1 as an accumulate, so these values cannot be set.
  - Otherwise IDLE → WRITE with `mem_wdata` = {value, 16'h0000}, then WR_WAIT, then RESP with accept and `resp_accum` = 0.
- RESP holds `resp_valid` and the response fields stable until `resp_ready`, then returns to IDLE.
- `mem_rdindex` = latched client from the handshake edge until the RESP exit. It is 0 in IDLE.
- `mem_we` is high for exactly one cycle (WRITE) per accepted order. It is never high in any other state.
- `reject_cnt` increments on the RESP exit when `resp_accept`=0, and saturates at 16'hFFFF.

## Timing
- Reset values: state IDLE, `ord_ready` 0 during the reset cycle and 1 the cycle after, `mem_we` 0, `mem_wdata` 0, `mem_rdindex` 0, `resp_valid` 0, `resp_accept` 0, `resp_client` 0, `resp_accum` 0, `reject_cnt` 0.
- Handshake edge = T0.
- Accepted trade:
  - RD_WAIT T0+1..T0+RD_LAT.
  - CHECK T0+RD_LAT+1.
  - `mem_we` at T0+RD_LAT+2.
  - `resp_valid` from T0+RD_LAT+WR_LAT+3, which is T0+13 with defaults.
- Rejected trade: `resp_valid` from T0+RD_LAT+2 (T0+6).
- Set-max:
  - `mem_we` at T0+1, `resp_valid` from T0+WR_LAT+2 (T0+8).
  - Invalid max: `resp_valid` from T0+1.
- `resp_ready` held high: RESP lasts 1 cycle. The next `ord_ready` comes 1 cycle after the RESP exit. Back-to-back orders to the same client therefore see the updated word.
- `ord_valid` outside IDLE is ignored and nothing is latched.
- Reset mid-operation: immediate return to IDLE. The latched order is discarded, no response is produced, `mem_we` is deasserted, and `reject_cnt` is cleared. A write strobe already issued is not retracted.
- `resp_ready` high while `resp_valid` low has no effect.

## Test plan
- Client 5 word 0x0064_0010, trade 0x20 → `mem_we` pulse with `mem_wdata`=0x0000_0020, `resp_accept`=1, `resp_accum`=0x30, `resp_valid` at T0+13.
- Client 5 word 0x0064_0050, trade 0x20 → reject, `resp_accum`=0x50, no `mem_we`, `resp_valid` at T0+6, `reject_cnt`=1.
- Limit edge cases:
  - Word 0x0064_0044, trade 0x20 (sum = max) → accept.
  - Word 0xFFFF_FFF0, trade 0x20 (overflow) → reject.
  - Word 0x0000_0000 → reject.
- Set-max:
  - Set-max 0x0200 on client 9 → `mem_wdata`=0x0200_0000, accept at T0+8.
  - Set-max 0x0001 → reject at T0+1, no `mem_we`.
- Backpressure and overlap:
  - `resp_ready` low for 5 cycles → response fields stable, `ord_ready`=0, a second `ord_valid` is not latched.
  - Release → second order accepted 1 cycle after the RESP exit.
- Assert `rst` during WR_WAIT → next cycle IDLE, all outputs at reset values, no `resp_valid`. A fresh trade then completes normally.
